// File: rtl/speaker_poly.sv
// speaker_poly: polyphonic square-wave voices, panned/mixed, serialised as left-justified stereo; define SPEAKER_MIX_SAT_EN to clamp the mix instead of wrapping.
module speaker_poly #(
  parameter int                  VOICES   = 2,
  parameter int                  DIV_W    = 20,
  parameter int                  SAMPLE_W = 16,
  parameter logic [SAMPLE_W-1:0] AMP      = 16'h2000,
  parameter int                  BCK_HALF = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VOICES*DIV_W-1:0] note_div,
  input  logic [VOICES-1:0]       voice_en,
  input  logic [VOICES-1:0]       voice_pan,
  input  logic                    mono,
  output logic                    frame_strobe,
  output logic                    audio_appsel,
  output logic                    audio_sysclk,
  output logic                    audio_bck,
  output logic                    audio_ws,
  output logic                    audio_data
);
  localparam int FW = 2 * SAMPLE_W;
  localparam int CW = $clog2(FW);
  localparam int BW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
`ifdef SPEAKER_MIX_SAT_EN
  localparam int ACC_W = SAMPLE_W + $clog2(VOICES) + 1;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'($signed({1'b0, {(SAMPLE_W-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  function automatic logic [SAMPLE_W-1:0] reduce(input logic signed [ACC_W-1:0] s);
    return (s > HI) ? {1'b0, {(SAMPLE_W-1){1'b1}}} : (s < LO) ? {1'b1, {(SAMPLE_W-1){1'b0}}} : s[SAMPLE_W-1:0];
  endfunction
`else
  // Wrapping only needs the low bits, so accumulate at sample width directly.
  localparam int ACC_W = SAMPLE_W;
  function automatic logic [SAMPLE_W-1:0] reduce(input logic signed [ACC_W-1:0] s);
    return s;
  endfunction
`endif
  localparam logic signed [ACC_W-1:0] POS = ACC_W'($signed(AMP));

  logic [DIV_W-1:0]        cnt_q [VOICES];
  logic [DIV_W-1:0]        cnt_d [VOICES];
  logic [VOICES-1:0]       ph_q, ph_d;
  logic [SAMPLE_W-1:0]     left_q, left_d, right_q, right_d;
  logic signed [ACC_W-1:0] left_sum, right_sum, samp;
  logic [DIV_W-1:0]        div;
  logic                    act, wrap;

  always_comb begin
    left_sum  = '0;
    right_sum = '0;
    samp      = '0;
    div       = '0;
    act       = 1'b0;
    wrap      = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      div       = note_div[i*DIV_W +: DIV_W];
      act       = voice_en[i] && (div != '0);
      wrap      = cnt_q[i] >= div - DIV_W'(1);
      cnt_d[i]  = (!act || wrap) ? '0 : cnt_q[i] + DIV_W'(1);
      ph_d[i]   = act && (wrap ? !ph_q[i] : ph_q[i]);
      samp      = !act ? '0 : ph_q[i] ? POS : -POS;
      left_sum  = left_sum + ((mono || !voice_pan[i]) ? samp : '0);
      right_sum = right_sum + ((mono || voice_pan[i]) ? samp : '0);
    end
    left_d  = reduce(left_sum);
    right_d = reduce(right_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) cnt_q[i] <= '0;
      ph_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) cnt_q[i] <= cnt_d[i];
      ph_q    <= ph_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  logic [BW-1:0] bck_cnt_q, bck_cnt_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] sh_q, sh_d;
  logic          bck_q, bck_d, strobe_q, strobe_d, tc, fall, last;

  always_comb begin
    tc        = bck_cnt_q == BW'(BCK_HALF - 1);
    fall      = tc && bck_q;
    last      = bit_cnt_q == CW'(FW - 1);
    bck_cnt_d = tc ? '0 : bck_cnt_q + BW'(1);
    bck_d     = tc ? !bck_q : bck_q;
    bit_cnt_d = !fall ? bit_cnt_q : last ? '0 : bit_cnt_q + CW'(1);
    sh_d      = !fall ? sh_q : last ? {left_q, right_q} : {sh_q[FW-2:0], 1'b0};
    strobe_d  = fall && last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_cnt_q <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      bck_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      bck_cnt_q <= bck_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      bck_q     <= bck_d;
      strobe_q  <= strobe_d;
    end
  end

  assign frame_strobe = strobe_q;
  assign audio_appsel = 1'b1;
  assign audio_sysclk = clk;
  assign audio_bck    = bck_q;
  assign audio_ws     = bit_cnt_q >= CW'(SAMPLE_W);
  assign audio_data   = sh_q[FW-1];
endmodule

// File: tb/tb_speaker_poly.sv
// tb_speaker_poly: directed checks of voice timing, mixing, saturation and serial framing.
module tb_speaker_poly;
  logic        clk = 1'b0, rst = 1'b1, mono = 1'b0;
  logic [39:0] note_div = '0;
  logic [1:0]  voice_en = '0, voice_pan = '0;
  logic        fs, appsel, sysclk, bck, ws, data;
  logic [39:0] note_div2 = {20'd8, 20'd8};
  logic [1:0]  voice_en2 = 2'b11, voice_pan2 = 2'b00;
  logic        mono2 = 1'b0;
  logic        fs2, appsel2, sysclk2, bck2, ws2, data2;
  int          errors = 0, checks = 0;
`ifdef SPEAKER_MIX_SAT_EN
  localparam logic [15:0] SAT_P1 = 16'h7FFF, SAT_P0 = 16'h8000;
`else
  localparam logic [15:0] SAT_P1 = 16'hC000, SAT_P0 = 16'h4000;
`endif

  speaker_poly dut (
    .clk(clk), .rst(rst), .note_div(note_div), .voice_en(voice_en), .voice_pan(voice_pan), .mono(mono),
    .frame_strobe(fs), .audio_appsel(appsel), .audio_sysclk(sysclk), .audio_bck(bck), .audio_ws(ws), .audio_data(data)
  );

  speaker_poly #(.AMP(16'h6000)) dut2 (
    .clk(clk), .rst(rst), .note_div(note_div2), .voice_en(voice_en2), .voice_pan(voice_pan2), .mono(mono2),
    .frame_strobe(fs2), .audio_appsel(appsel2), .audio_sysclk(sysclk2), .audio_bck(bck2), .audio_ws(ws2), .audio_data(data2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int data_ones, early_strobes;
    voice_en = '0; note_div = '0; voice_pan = '0; mono = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if ({fs, bck, ws, data, appsel} !== 5'b00001) begin
      errors++; $display("FAIL reset_outputs got %b exp 00001", {fs, bck, ws, data, appsel});
    end
    checks++;
    if (sysclk !== clk) begin errors++; $display("FAIL sysclk got %b exp %b", sysclk, clk); end
    rst = 1'b0;
    data_ones = 0; early_strobes = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (data !== 1'b0) data_ones++;
      if (k < 256 && fs !== 1'b0) early_strobes++;
      if (k == 3) begin checks++; if (bck !== 1'b0) begin errors++; $display("FAIL bck_k3 got %b exp 0", bck); end end
      if (k == 4) begin checks++; if (bck !== 1'b1) begin errors++; $display("FAIL bck_rise_k4 got %b exp 1", bck); end end
      if (k == 7) begin checks++; if (bck !== 1'b1) begin errors++; $display("FAIL bck_k7 got %b exp 1", bck); end end
      if (k == 8) begin checks++; if (bck !== 1'b0) begin errors++; $display("FAIL bck_fall_k8 got %b exp 0", bck); end end
      if (k == 127) begin checks++; if (ws !== 1'b0) begin errors++; $display("FAIL ws_k127 got %b exp 0", ws); end end
      if (k == 128) begin checks++; if (ws !== 1'b1) begin errors++; $display("FAIL ws_k128 got %b exp 1", ws); end end
      if (k == 256) begin checks++; if (fs !== 1'b1) begin errors++; $display("FAIL first_strobe_k256 got %b exp 1", fs); end end
    end
    checks++;
    if (early_strobes !== 0) begin errors++; $display("FAIL early_strobes got %0d exp 0", early_strobes); end
    checks++;
    if (data_ones !== 0) begin errors++; $display("FAIL frame0_data got %0d ones exp 0", data_ones); end
  endtask

  task automatic test_single_voice();
    note_div = {20'd0, 20'd4}; voice_en = 2'b01; voice_pan = 2'b00; mono = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) begin checks++; if (dut.ph_q[0] !== 1'b0) begin errors++; $display("FAIL sv_phase_k3 got %b exp 0", dut.ph_q[0]); end end
      if (k == 4) begin checks++; if (dut.ph_q[0] !== 1'b1) begin errors++; $display("FAIL sv_phase_k4 got %b exp 1", dut.ph_q[0]); end end
      if (k == 8) begin checks++; if (dut.ph_q[0] !== 1'b0) begin errors++; $display("FAIL sv_phase_k8 got %b exp 0", dut.ph_q[0]); end end
      if (k == 4) begin checks++; if (dut.left_q !== 16'hE000) begin errors++; $display("FAIL sv_left_k4 got %h exp e000", dut.left_q); end end
      if (k == 5) begin checks++; if (dut.left_q !== 16'h2000) begin errors++; $display("FAIL sv_left_k5 got %h exp 2000", dut.left_q); end end
      if (k == 9) begin checks++; if (dut.left_q !== 16'hE000) begin errors++; $display("FAIL sv_left_k9 got %h exp e000", dut.left_q); end end
      if (k == 5) begin checks++; if (dut.right_q !== 16'h0000) begin errors++; $display("FAIL sv_right_k5 got %h exp 0000", dut.right_q); end end
    end
  endtask

  task automatic test_serial_word();
    logic [15:0] lw, rw;
    int ws_bad, unstable, off, j;
    logic prev;
    note_div = {20'd0, 20'hFFFFF}; voice_en = 2'b01; voice_pan = 2'b00; mono = 1'b0;
    do_reset();
    lw = '0; rw = '0; ws_bad = 0; unstable = 0; prev = 1'b0;
    for (int k = 1; k <= 511; k++) begin
      tick();
      if (k == 256) begin
        checks++;
        if ({fs, ws, data} !== 3'b101) begin errors++; $display("FAIL sw_load got fs/ws/data %b exp 101", {fs, ws, data}); end
      end
      if (k > 256) begin
        off = (k - 256) % 8;
        j = (k - 256) / 8;
        if (off != 0 && data !== prev) unstable++;
        if (off == 4) begin
          if (j < 16) lw = {lw[14:0], data}; else rw = {rw[14:0], data};
          if (ws !== (j >= 16)) ws_bad++;
        end
      end
      prev = data;
    end
    checks++;
    if (lw !== 16'hE000) begin errors++; $display("FAIL sw_left_word got %h exp e000", lw); end
    checks++;
    if (rw !== 16'h0000) begin errors++; $display("FAIL sw_right_word got %h exp 0000", rw); end
    checks++;
    if (ws_bad !== 0) begin errors++; $display("FAIL sw_ws got %0d bad exp 0", ws_bad); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL sw_bit_stability got %0d changes exp 0", unstable); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) begin checks++; if (dut2.left_q !== SAT_P0) begin errors++; $display("FAIL sat_phase0 got %h exp %h", dut2.left_q, SAT_P0); end end
      if (k == 12) begin checks++; if (dut2.left_q !== SAT_P1) begin errors++; $display("FAIL sat_phase1 got %h exp %h", dut2.left_q, SAT_P1); end end
      if (k == 12) begin checks++; if (dut2.right_q !== 16'h0000) begin errors++; $display("FAIL sat_right got %h exp 0000", dut2.right_q); end end
    end
  endtask

  task automatic test_mono_divdec();
    note_div = {20'd0, 20'd100}; voice_en = 2'b01; voice_pan = 2'b01; mono = 1'b1;
    do_reset();
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if ({dut.left_q, dut.right_q} !== 32'hE000_E000) begin errors++; $display("FAIL mono_mix got %h exp e000e000", {dut.left_q, dut.right_q}); end
      end
      if (k == 50) begin
        checks++;
        if ({dut.cnt_q[0], dut.ph_q[0]} !== {20'd50, 1'b0}) begin errors++; $display("FAIL dd_k50 got cnt %0d ph %b exp 50 0", dut.cnt_q[0], dut.ph_q[0]); end
        note_div[19:0] = 20'd10;
      end
      if (k == 51) begin
        checks++;
        if ({dut.cnt_q[0], dut.ph_q[0]} !== {20'd0, 1'b1}) begin errors++; $display("FAIL dd_k51 got cnt %0d ph %b exp 0 1", dut.cnt_q[0], dut.ph_q[0]); end
      end
      if (k == 52) begin
        checks++;
        if ({dut.left_q, dut.right_q} !== 32'h2000_2000) begin errors++; $display("FAIL mono_mix_k52 got %h exp 20002000", {dut.left_q, dut.right_q}); end
      end
      if (k == 60) begin checks++; if (dut.ph_q[0] !== 1'b1) begin errors++; $display("FAIL dd_k60 got %b exp 1", dut.ph_q[0]); end end
      if (k == 61) begin checks++; if (dut.ph_q[0] !== 1'b0) begin errors++; $display("FAIL dd_k61 got %b exp 0", dut.ph_q[0]); end end
    end
  endtask

  task automatic test_midframe_reset();
    int first;
    note_div = {20'd0, 20'hFFFFF}; voice_en = 2'b01; voice_pan = 2'b00; mono = 1'b0;
    do_reset();
    repeat (341) tick();
    checks++;
    if ({bck, dut.bit_cnt_q} !== {1'b1, 5'd10}) begin errors++; $display("FAIL mr_pre got bck %b bit_cnt %0d exp 1 10", bck, dut.bit_cnt_q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bck, ws, data, fs} !== 4'b0000) begin errors++; $display("FAIL mr_outputs got %b exp 0000", {bck, ws, data, fs}); end
    checks++;
    if ({dut.bck_cnt_q, dut.bit_cnt_q, dut.cnt_q[0], dut.left_q} !== '0) begin
      errors++; $display("FAIL mr_counters got bck_cnt %0d bit_cnt %0d cnt %0d left %h exp 0", dut.bck_cnt_q, dut.bit_cnt_q, dut.cnt_q[0], dut.left_q);
    end
    first = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (fs === 1'b1 && first == 0) first = k;
    end
    checks++;
    if (first !== 256) begin errors++; $display("FAIL mr_next_strobe got %0d exp 256", first); end
  endtask

  initial begin
    test_reset();
    test_single_voice();
    test_serial_word();
    test_saturation();
    test_mono_divdec();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
